// File: rtl/interleaver_multimode.sv
// Ping-pong 802.16 block interleaver (QPSK/16QAM/64QAM), one bit per cycle in and out.
// Define INTLV_BLKCNT_EN to add the blk_count port and its completed-block counter.
module interleaver_multimode #(
  parameter int NCBPS_MAX = 576,
  parameter int D         = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mode,
  input  logic        data_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic        data_out,
  output logic        valid_out,
  input  logic        ready_in
`ifdef INTLV_BLKCNT_EN
  ,
  output logic [15:0] blk_count
`endif
);
  localparam int AW = $clog2(NCBPS_MAX);
  localparam logic [AW-1:0] LAST_Q   = AW'(191);
  localparam logic [AW-1:0] LAST_16  = AW'(383);
  localparam logic [AW-1:0] LAST_64  = AW'(575);
  localparam logic [AW-1:0] NDIV_Q   = AW'(192 / D);
  localparam logic [AW-1:0] NDIV_16  = AW'(384 / D);
  localparam logic [AW-1:0] NDIV_64  = AW'(576 / D);
  localparam logic [AW-1:0] COL_LAST = AW'(D - 1);

  typedef enum logic {W_IDLE, W_FILL}  w_state_t;
  typedef enum logic {R_IDLE, R_DRAIN} r_state_t;

  w_state_t        r_wstate, w_wstate_nxt;
  r_state_t        r_rstate, w_rstate_nxt;
  logic            r_mem [0:1][0:NCBPS_MAX-1];
  logic [1:0]      r_full;
  logic [AW-1:0]   r_last [0:1];
  logic            r_wbank, r_rbank;
  logic [1:0]      r_ws;
  logic [AW-1:0]   r_wndiv, r_wlast;
  logic [AW-1:0]   r_k, r_col, r_row, r_m;
  logic [1:0]      r_rm, r_cm;
  logic [AW-1:0]   r_raddr;
  logic            r_dout, r_vout;

  logic [1:0]      w_mode_s, w_cur_s, w_adj;
  logic [AW-1:0]   w_mode_ndiv, w_mode_last, w_cur_ndiv, w_waddr, w_faddr;
  logic            w_idle, w_accept, w_wlast_bit, w_fill_done;
  logic            w_slot_free, w_rd_full, w_fetch, w_fetch_last, w_rdata;
  logic [1:0]      w_set_vec, w_clr_vec;

  // Block geometry selected by the mode input; reserved code falls back to QPSK.
  always_comb begin
    w_mode_s    = 2'd1;
    w_mode_ndiv = NDIV_Q;
    w_mode_last = LAST_Q;
    case (mode)
      2'd1: begin
        w_mode_s    = 2'd2;
        w_mode_ndiv = NDIV_16;
        w_mode_last = LAST_16;
      end
      2'd2: begin
        w_mode_s    = 2'd3;
        w_mode_ndiv = NDIV_64;
        w_mode_last = LAST_64;
      end
      default: begin
        w_mode_s    = 2'd1;
        w_mode_ndiv = NDIV_Q;
        w_mode_last = LAST_Q;
      end
    endcase
  end

  assign w_idle      = (r_wstate == W_IDLE);
  assign w_cur_s     = w_idle ? w_mode_s : r_ws;
  assign w_cur_ndiv  = w_idle ? w_mode_ndiv : r_wndiv;
  assign ready_out   = ~reset & ~r_full[r_wbank];
  assign w_accept    = valid_in & ready_out;
  assign w_wlast_bit = ~w_idle & (r_k == r_wlast);
  assign w_fill_done = w_accept & w_wlast_bit;

  // floor(D*m/Ncbps) equals the column and Ncbps is a multiple of s, so the
  // second permutation reduces to ((row mod s) - (col mod s)) mod s.
  always_comb begin
    w_adj = 2'd0;
    if (r_rm >= r_cm) begin
      w_adj = r_rm - r_cm;
    end else begin
      w_adj = 2'(({1'b0, r_rm} + {1'b0, w_cur_s}) - {1'b0, r_cm});
    end
  end

  assign w_waddr = r_m - {{(AW-2){1'b0}}, r_rm} + {{(AW-2){1'b0}}, w_adj};

  // Write FSM next state.
  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE: begin
        if (w_accept) w_wstate_nxt = W_FILL;
        else          w_wstate_nxt = W_IDLE;
      end
      W_FILL: begin
        if (w_fill_done) w_wstate_nxt = W_IDLE;
        else             w_wstate_nxt = W_FILL;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Write FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_wstate <= W_IDLE;
    else       r_wstate <= w_wstate_nxt;
  end

  // Per-block mode latch and incremental row/column/m counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wbank   <= 1'b0;
      r_ws      <= 2'd1;
      r_wndiv   <= {AW{1'b0}};
      r_wlast   <= {AW{1'b0}};
      r_last[0] <= {AW{1'b0}};
      r_last[1] <= {AW{1'b0}};
      r_k       <= {AW{1'b0}};
      r_col     <= {AW{1'b0}};
      r_row     <= {AW{1'b0}};
      r_m       <= {AW{1'b0}};
      r_rm      <= 2'd0;
      r_cm      <= 2'd0;
    end else if (w_accept) begin
      if (w_idle) begin
        r_ws            <= w_mode_s;
        r_wndiv         <= w_mode_ndiv;
        r_wlast         <= w_mode_last;
        r_last[r_wbank] <= w_mode_last;
      end
      if (w_fill_done) begin
        r_wbank <= ~r_wbank;
        r_k     <= {AW{1'b0}};
        r_col   <= {AW{1'b0}};
        r_row   <= {AW{1'b0}};
        r_m     <= {AW{1'b0}};
        r_rm    <= 2'd0;
        r_cm    <= 2'd0;
      end else begin
        r_k <= r_k + AW'(1);
        if (r_col == COL_LAST) begin
          r_col <= {AW{1'b0}};
          r_cm  <= 2'd0;
          r_row <= r_row + AW'(1);
          r_m   <= r_row + AW'(1);
          r_rm  <= (r_rm == w_cur_s - 2'd1) ? 2'd0 : r_rm + 2'd1;
        end else begin
          r_col <= r_col + AW'(1);
          r_m   <= r_m + w_cur_ndiv;
          r_cm  <= (r_cm == w_cur_s - 2'd1) ? 2'd0 : r_cm + 2'd1;
        end
      end
    end
  end

  // Bank storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wbank][w_waddr] <= data_in;
  end

  assign w_slot_free = ~r_vout | ready_in;
  assign w_rd_full   = r_full[r_rbank];
  assign w_rdata     = r_mem[r_rbank][w_faddr];

  // The bank is released when its last bit moves into the output register,
  // which keeps input and output streaming back to back.
  always_comb begin
    w_fetch = 1'b0;
    w_faddr = r_raddr;
    case (r_rstate)
      R_IDLE: begin
        w_fetch = w_rd_full & w_slot_free;
        w_faddr = {AW{1'b0}};
      end
      R_DRAIN: begin
        w_fetch = w_slot_free;
        w_faddr = r_raddr;
      end
      default: begin
        w_fetch = 1'b0;
        w_faddr = {AW{1'b0}};
      end
    endcase
  end

  assign w_fetch_last = w_fetch & (w_faddr == r_last[r_rbank]);

  // Read FSM next state.
  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE: begin
        if (w_fetch && !w_fetch_last) w_rstate_nxt = R_DRAIN;
        else                          w_rstate_nxt = R_IDLE;
      end
      R_DRAIN: begin
        if (w_fetch_last) w_rstate_nxt = R_IDLE;
        else              w_rstate_nxt = R_DRAIN;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Read FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_rstate <= R_IDLE;
    else       r_rstate <= w_rstate_nxt;
  end

  // Read address, bank pointer and registered output stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rbank <= 1'b0;
      r_raddr <= {AW{1'b0}};
      r_dout  <= 1'b0;
      r_vout  <= 1'b0;
    end else if (w_fetch) begin
      r_dout <= w_rdata;
      r_vout <= 1'b1;
      if (w_fetch_last) begin
        r_raddr <= {AW{1'b0}};
        r_rbank <= ~r_rbank;
      end else begin
        r_raddr <= w_faddr + AW'(1);
      end
    end else if (ready_in) begin
      r_vout <= 1'b0;
    end
  end

  assign w_set_vec = w_fill_done  ? (2'b01 << r_wbank) : 2'b00;
  assign w_clr_vec = w_fetch_last ? (2'b01 << r_rbank) : 2'b00;

  // Full flags; a set and a clear on opposite banks in one cycle both apply.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_full <= 2'b00;
    else       r_full <= (r_full | w_set_vec) & ~w_clr_vec;
  end

  assign data_out  = r_dout;
  assign valid_out = r_vout;

`ifdef INTLV_BLKCNT_EN
  logic [15:0] r_blk_cnt;

  // Completed-block counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             r_blk_cnt <= 16'd0;
    else if (w_fetch_last) r_blk_cnt <= r_blk_cnt + 16'd1;
    else                   r_blk_cnt <= r_blk_cnt;
  end

  assign blk_count = r_blk_cnt;
`endif

endmodule

// File: tb/tb_interleaver_multimode.sv
// Scoreboard bench for interleaver_multimode: directed single-bit blocks with
// hand-computed interleaved output positions, backpressure, mode change and reset.
module tb_interleaver_multimode;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] mode = 2'd0;
  logic       data_in = 1'b0;
  logic       valid_in = 1'b0;
  logic       ready_out;
  logic       data_out;
  logic       valid_out;
  logic       ready_in = 1'b0;
`ifdef INTLV_BLKCNT_EN
  logic [15:0] blk_count;
`endif

  int  checks = 0;
  int  errors = 0;
  int  stalls = 0;
  int  out_n  = 0;
  int  vcount = 0;
  bit  sb[$];
  bit  stall_prev = 1'b0;
  bit  stall_data = 1'b0;

  interleaver_multimode dut (
    .clk      (clk),
    .reset    (reset),
    .mode     (mode),
    .data_in  (data_in),
    .valid_in (valid_in),
    .ready_out(ready_out),
    .data_out (data_out),
    .valid_out(valid_out),
    .ready_in (ready_in)
`ifdef INTLV_BLKCNT_EN
    ,
    .blk_count(blk_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Monitor: hold check while stalled, scoreboard compare on every transfer.
  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (valid_out) vcount++;
      if (stall_prev) begin
        checks++;
        if (valid_out !== 1'b1 || data_out !== stall_data) begin
          errors++;
          $display("FAIL hold: valid_out=%0b data_out=%0b required 1/%0b", valid_out, data_out, stall_data);
        end
      end
      if (valid_out && ready_in) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: transfer #%0d with empty scoreboard, required none", out_n);
        end else begin
          bit e;
          e = sb.pop_front();
          if (data_out !== e) begin
            errors++;
            $display("FAIL out_bit #%0d: got %0b required %0b", out_n, data_out, e);
          end
        end
        out_n++;
      end
      stall_prev = valid_out && !ready_in;
      stall_data = data_out;
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic send_bit(input logic b, input logic [1:0] md);
    int  n;
    logic ok;
    data_in = b; mode = md; valid_in = 1'b1; n = 0; ok = 1'b0;
    while (!ok && n < 2000) begin
      @(negedge clk);
      ok = ready_out;
      if (!ok) stalls++;
      @(posedge clk); #1;
      n++;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout: ready_out stayed 0, required 1");
    end
    valid_in = 1'b0;
  endtask

  // Push the expected block, then stream it; s* are set input positions,
  // e* the hand-computed interleaved output positions (-1 = unused).
  task automatic run(input logic [1:0] md, input int n,
                     input int s0, input int s1, input int s2, input int s3,
                     input int e0, input int e1, input int e2, input int e3,
                     input bit toggle, input bit chk_lat);
    bit b;
    logic [1:0] m;
    for (int i = 0; i < n; i++) begin
      b = (i == e0) || (i == e1) || (i == e2) || (i == e3);
      sb.push_back(b);
    end
    for (int k = 0; k < n; k++) begin
      b = (k == s0) || (k == s1) || (k == s2) || (k == s3);
      m = md;
      if (toggle && k > 0) m = 2'(k % 4);
      send_bit(b, m);
    end
    if (chk_lat) begin
      check("lat_T+1_valid", int'(valid_out), 0);
      @(posedge clk); #1;
      check("lat_T+2_valid", int'(valid_out), 1);
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 4000) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_remaining"}, sb.size(), 0);
    @(posedge clk); #1;
    check({name, "_valid_low"}, int'(valid_out), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready_out", int'(ready_out), 0);
    check("rst_valid_out", int'(valid_out), 0);
    check("rst_data_out", int'(data_out), 0);
    reset = 1'b0;
    #1;
    check("post_rst_ready", int'(ready_out), 1);
    @(posedge clk); #1;
    ready_in = 1'b1;

    // Single-bit placement per mode, with output latency.
    run(2'd0, 192, 1, -1, -1, -1, 12, -1, -1, -1, 1'b0, 1'b1);
    wait_drain("qpsk_k1");
    run(2'd1, 384, 1, -1, -1, -1, 25, -1, -1, -1, 1'b0, 1'b1);
    wait_drain("qam16_k1");
    run(2'd2, 576, 1, -1, -1, -1, 38, -1, -1, -1, 1'b0, 1'b1);
    wait_drain("qam64_k1");
    run(2'd3, 192, 0, -1, -1, -1, 0, -1, -1, -1, 1'b0, 1'b0);
    wait_drain("reserved_k0");

    // Continuous back-to-back stream: no input stall expected.
    stalls = 0;
    run(2'd0, 192, 5, -1, -1, -1, 60, -1, -1, -1, 1'b0, 1'b0);
    run(2'd0, 192, 0, 16, 17, 191, 0, 1, 13, 191, 1'b0, 1'b0);
    run(2'd1, 384, 0, 2, 17, -1, 0, 48, 24, -1, 1'b0, 1'b0);
    run(2'd2, 576, 0, 2, 17, -1, 0, 73, 36, -1, 1'b0, 1'b0);
    check("stream_input_stalls", stalls, 0);
    wait_drain("stream");

    // Backpressure: two blocks fill both banks, third stalls until ready_in.
    ready_in = 1'b0;
    run(2'd0, 192, 1, -1, -1, -1, 12, -1, -1, -1, 1'b0, 1'b0);
    check("bp_ready_after_191", int'(ready_out), 1);
    run(2'd0, 192, 0, 16, 17, 191, 0, 1, 13, 191, 1'b0, 1'b0);
    check("bp_ready_after_383", int'(ready_out), 0);
    fork
      run(2'd0, 192, 5, -1, -1, -1, 60, -1, -1, -1, 1'b0, 1'b0);
      begin
        repeat (50) @(posedge clk);
        #1;
        check("bp_still_stalled", int'(ready_out), 0);
        check("bp_valid_held", int'(valid_out), 1);
        ready_in = 1'b1;
      end
    join
    wait_drain("backpressure");

    // Mode toggled during a 64QAM block, then a QPSK block.
    run(2'd2, 576, 1, 17, -1, -1, 38, 36, -1, -1, 1'b1, 1'b0);
    run(2'd0, 192, 1, 191, -1, -1, 12, 191, -1, -1, 1'b0, 1'b0);
    wait_drain("mode_change");

    // Reset in the middle of a block discards it entirely.
    for (int k = 0; k < 100; k++) send_bit(k == 1, 2'd0);
    reset = 1'b1;
    #1;
    check("mid_rst_ready_out", int'(ready_out), 0);
    check("mid_rst_valid_out", int'(valid_out), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst_post_ready", int'(ready_out), 1);
    vcount = 0;
    repeat (250) @(posedge clk);
    #1;
    check("mid_rst_no_output", vcount, 0);
`ifdef INTLV_BLKCNT_EN
    check("blk_count_after_reset", int'(blk_count), 0);
`endif
    run(2'd1, 384, 1, -1, -1, -1, 25, -1, -1, -1, 1'b0, 1'b1);
    wait_drain("after_reset");
`ifdef INTLV_BLKCNT_EN
    check("blk_count_one", int'(blk_count), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/interleaver_multimode.md
INTERLEAVER_MULTIMODE -- requirements
Module: interleaver_multimode

Interface
REQ-001 SHALL have parameter NCBPS_MAX, default 576, meaning the largest block size in bits, which sets the bank depth.
REQ-002 SHALL have parameter D, default 16, meaning the interleaver column count (802.16 d).
REQ-003 SHALL have port clk, input, 1 bit: single clock, all logic on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port mode, input, 2 bits: 0=QPSK (Ncbps=192, s=1), 1=16QAM (Ncbps=384, s=2), 2=64QAM (Ncbps=576, s=3), 3=reserved and treated as QPSK.
REQ-006 SHALL have port data_in, input, 1 bit: serial coded bit from the FEC.
REQ-007 SHALL have port valid_in, input, 1 bit: data_in is valid.
REQ-008 SHALL have port ready_out, output, 1 bit: the block can accept data_in this cycle.
REQ-009 SHALL have port data_out, output, 1 bit: serial interleaved bit.
REQ-010 SHALL have port valid_out, output, 1 bit: data_out is valid.
REQ-011 SHALL have port ready_in, input, 1 bit: downstream accepts data_out this cycle.
REQ-012 SHALL have port blk_count, output, 16 bits: count of completed output blocks (INTLV_BLKCNT_EN only).

Function
REQ-013 SHALL accept an input bit only on a cycle where valid_in and ready_out are both high.
REQ-014 SHALL transfer an output bit only on a cycle where valid_out and ready_in are both high.
REQ-015 SHALL hold data_out and valid_out stable while valid_out is high and ready_in is low.
REQ-016 SHALL latch mode per block on the first accepted bit (k=0) and store Ncbps and s with that bank; mode changes mid-block SHALL be ignored.
REQ-017 SHALL write input bit k to address j of the current write bank, where m=(Ncbps/D)*(k mod D)+floor(k/D) and j=s*floor(m/s)+((m+Ncbps-floor(D*m/Ncbps)) mod s).
REQ-018 SHALL compute j with counters and bounded add/compare logic, with no run-time divider; all index widths SHALL be $clog2(NCBPS_MAX).
REQ-019 SHALL use two banks of NCBPS_MAX bits (ping-pong); each bank has a full flag and a stored Ncbps.
REQ-020 Write FSM SHALL have states W_IDLE and W_FILL: W_IDLE moves to W_FILL on the first accepted bit; W_FILL returns to W_IDLE when bit Ncbps-1 is accepted, which sets the bank full flag and toggles the write bank.
REQ-021 SHALL drive ready_out = 1 exactly when the current write bank's full flag is clear.
REQ-022 Read FSM SHALL have states R_IDLE and R_DRAIN: R_IDLE moves to R_DRAIN when the read bank is full; reads SHALL be sequential, address 0 to Ncbps-1 of that bank.
REQ-023 SHALL transfer the last output bit (address Ncbps-1) by clearing that bank's full flag, toggling the read bank and returning to R_IDLE.
REQ-024 Latency: if the last input bit of a block is accepted in cycle T and the read side is idle, valid_out SHALL rise in cycle T+2 with output bit 0.
REQ-025 With continuous valid_in and ready_in, SHALL sustain 1 bit per cycle with no gap on the input side.
REQ-026 If a bank's full flag is cleared in the same cycle the other bank's fill completes, both updates SHALL take effect and ready_out SHALL remain 1.
REQ-027 Read address SHALL wrap to 0 per block Ncbps, so a mixed-mode sequence of blocks is output in order, each with its own length.

Reset
REQ-028 While reset is high, SHALL force: both full flags 0, both FSMs idle, all counters 0, bank pointers 0, ready_out 0, valid_out 0, data_out 0, blk_count 0.
REQ-029 In the first cycle after reset deasserts, ready_out SHALL be 1.
REQ-030 Reset mid-block SHALL discard partial and full banks, and SHALL output no bits from them.
REQ-031 Memory contents need not be reset.

Configuration
REQ-032 With macro INTLV_BLKCNT_EN defined, SHALL provide blk_count, incremented on each REQ-023 event and wrapping 65535 to 0.
REQ-033 Without INTLV_BLKCNT_EN, the blk_count port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-034 QPSK, one block with only bit k=1 set, ready_in=1 -> 192 output bits, only output index 12 = 1; valid_out rises 2 cycles after the last input.
REQ-035 16QAM, bit k=1 set -> 384 outputs, only index 25 = 1; 64QAM, bit k=1 set -> 576 outputs, only index 38 = 1; k=0 maps to index 0 in all modes.
REQ-036 ready_in=0 throughout, two QPSK blocks streamed -> ready_out falls after bit 383; a third block stalls; raising ready_in resumes with no lost or duplicated bits.
REQ-037 Blocks in mode 2 then 0, with mode toggled during the first block -> 576 bits, then 192 bits, each correctly interleaved.
REQ-038 reset pulsed at input bit 100 of a block -> no valid_out; the next full block is output correctly; blk_count (if enabled) = 1 after it.
